// File: rtl/decodificador_display_mux_if.sv
// Bus between the datapath and the multiplexed display driver: load strobe,
// per-digit snapshot data going in, shared segment bus and anode lines coming out.
interface decodificador_display_mux_if #(
  parameter int N_DIGITOS = 4
);
  logic                     carrega;
  logic [4*N_DIGITOS-1:0]   valores;
  logic [N_DIGITOS-1:0]     habilita;
  logic [N_DIGITOS-1:0]     pisca;
  logic [N_DIGITOS-1:0]     pontos;
  logic [6:0]               seg;
  logic                     dp;
  logic [N_DIGITOS-1:0]     digito;
  logic                     fim_varredura;

  modport master (
    output carrega, valores, habilita, pisca, pontos,
    input  seg, dp, digito, fim_varredura
  );

  modport slave (
    input  carrega, valores, habilita, pisca, pontos,
    output seg, dp, digito, fim_varredura
  );
endinterface

// File: rtl/decodificador_display_mux.sv
// Scanned common-anode 7-segment driver: per-digit shadow registers and hex
// decode in lane instances, a shared prescaler/index/blink scanner, registered outputs.
module decodificador_display_mux_lane (
  input  logic       clock,
  input  logic       reset,
  input  logic       carrega,
  input  logic [3:0] valor,
  input  logic       hab,
  input  logic       pis,
  input  logic       pt,
  input  logic       fase,
  output logic [6:0] seg_lane,
  output logic       dp_lane
);
  logic [3:0] sh_valor;
  logic       sh_hab, sh_pis, sh_pt;
  logic [6:0] seg_dec;
  logic       apagado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_valor <= '0;
      sh_hab   <= 1'b0;
      sh_pis   <= 1'b0;
      sh_pt    <= 1'b0;
    end else if (carrega) begin
      sh_valor <= valor;
      sh_hab   <= hab;
      sh_pis   <= pis;
      sh_pt    <= pt;
    end
  end

  // a..g on bits 6..0, active low
  always_comb begin
    seg_dec = 7'b1111111;
    case (sh_valor)
      4'h0: seg_dec = 7'b0000001;
      4'h1: seg_dec = 7'b1001111;
      4'h2: seg_dec = 7'b0010010;
      4'h3: seg_dec = 7'b0000110;
      4'h4: seg_dec = 7'b1001100;
      4'h5: seg_dec = 7'b0100100;
      4'h6: seg_dec = 7'b0100000;
      4'h7: seg_dec = 7'b0001111;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0000100;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b1100000;
      4'hC: seg_dec = 7'b0110001;
      4'hD: seg_dec = 7'b1000010;
      4'hE: seg_dec = 7'b0110000;
      4'hF: seg_dec = 7'b0111000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_comb begin
    apagado  = ~sh_hab | (sh_pis & ~fase);
    seg_lane = apagado ? 7'b1111111 : seg_dec;
    dp_lane  = apagado ? 1'b1 : ~sh_pt;
  end
endmodule

module decodificador_display_mux #(
  parameter int N_DIGITOS        = 4,
  parameter int DIV_VARREDURA    = 50000,
  parameter int PISCA_VARREDURAS = 100
) (
  input logic clock,
  input logic reset,
  decodificador_display_mux_if.slave bus
);
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = $clog2(DIV_VARREDURA);
  localparam int PW = (PISCA_VARREDURAS > 1) ? $clog2(PISCA_VARREDURAS) : 1;

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [PW-1:0]                cont_pisca;
  logic                         fase;
  logic                         tick, ultimo, fim_nx;
  logic [N_DIGITOS-1:0]         digito_nx;
  logic [N_DIGITOS-1:0][6:0]    seg_lanes;
  logic [N_DIGITOS-1:0]         dp_lanes;

  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_lane
    decodificador_display_mux_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .carrega  (bus.carrega),
      .valor    (bus.valores[4*i +: 4]),
      .hab      (bus.habilita[i]),
      .pis      (bus.pisca[i]),
      .pt       (bus.pontos[i]),
      .fase     (fase),
      .seg_lane (seg_lanes[i]),
      .dp_lane  (dp_lanes[i])
    );
  end

  always_comb begin
    tick   = (cnt == CW'(DIV_VARREDURA - 1));
    ultimo = (idx == IW'(N_DIGITOS - 1));
    fim_nx = tick & ultimo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      cont_pisca <= '0;
      fase       <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= ultimo ? '0 : idx + 1'b1;
      // phase flips on the same edge that wraps the index back to digit 0
      if (fim_nx) begin
        if (cont_pisca == PW'(PISCA_VARREDURAS - 1)) begin
          cont_pisca <= '0;
          fase       <= ~fase;
        end else begin
          cont_pisca <= cont_pisca + 1'b1;
        end
      end
    end
  end

  // anodes released for the whole tick cycle so the segment bus can change unseen
  always_comb begin
    digito_nx = '1;
    if (!tick) digito_nx[idx] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.seg           <= 7'b1111111;
      bus.dp            <= 1'b1;
      bus.digito        <= '1;
      bus.fim_varredura <= 1'b0;
    end else begin
      bus.seg           <= seg_lanes[idx];
      bus.dp            <= dp_lanes[idx];
      bus.digito        <= digito_nx;
      bus.fim_varredura <= fim_nx;
    end
  end
endmodule

// File: tb/tb_decodificador_display_mux.sv
// Bench for decodificador_display_mux with N=4, DIV=4, PISCA=2: vector table plus
// hand sequences for reset, scan order, blink and load-on-tick; expectations go through a queue.
module tb_decodificador_display_mux;
  localparam int N = 4, D = 4, P = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  decodificador_display_mux_if #(.N_DIGITOS(N)) bus ();
  decodificador_display_mux #(.N_DIGITOS(N), .DIV_VARREDURA(D), .PISCA_VARREDURAS(P)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fim;
    bit         full;
  } exp_t;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  hab, pis, pts;
    int          dig;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  logic [6:0] hex_seg [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  exp_t sb[$];
  vec_t tab[$];
  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    e = sb.pop_front();
    chk({nm, " digito"}, bus.digito, e.dig);
    chk({nm, " fim"}, bus.fim_varredura, e.fim);
    if (e.full) begin
      chk({nm, " seg"}, bus.seg, e.seg);
      chk({nm, " dp"}, bus.dp, e.dp);
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] h, p, t);
    @(negedge clock);
    bus.carrega = 1'b1; bus.valores = v; bus.habilita = h; bus.pisca = p; bus.pontos = t;
    @(negedge clock);
    bus.carrega = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_fim();
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      if (bus.fim_varredura === 1'b1) ok = 1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_fim: got no pulse required one within 64 cycles");
    end
  endtask

  task automatic wait_digit(input int d, output bit ok);
    logic [3:0] alvo;
    alvo = ~(4'b0001 << d);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clock);
      if (bus.digito === alvo) ok = 1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_digit %0d: got no slot required one within 64 cycles", d);
    end
  endtask

  // called right after a fim_varredura sample; ends on the next one
  task automatic check_scan(input logic [15:0] v, input logic [3:0] vis, input logic [3:0] pts,
                            input string nm);
    for (int c = 0; c < 16; c++) begin
      exp_t e;
      int s;
      s = c / 4;
      e.full = (c % 4) != 3;
      e.dig  = e.full ? ~(4'b0001 << s) : 4'hF;
      e.seg  = vis[s] ? hex_seg[v[4*s +: 4]] : 7'b1111111;
      e.dp   = vis[s] ? ~pts[s] : 1'b1;
      e.fim  = (c == 15);
      sb.push_back(e);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      pop_cmp(nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.carrega = 0; bus.valores = '0; bus.habilita = '0; bus.pisca = '0; bus.pontos = '0;
    reset = 1'b1;

    for (int v = 0; v < 16; v++)
      tab.push_back('{{12'h000, 4'(v)}, 4'b0001, 4'b0000, 4'b0000, 0, hex_seg[v], 1'b1});
    tab.push_back('{16'hA5C3, 4'b1010, 4'b0000, 4'b0010, 0, 7'b1111111, 1'b1});
    tab.push_back('{16'hA5C3, 4'b1010, 4'b0000, 4'b0010, 1, 7'b0110001, 1'b0});
    tab.push_back('{16'hA5C3, 4'b1010, 4'b0000, 4'b0010, 2, 7'b1111111, 1'b1});
    tab.push_back('{16'hA5C3, 4'b1010, 4'b0000, 4'b0010, 3, 7'b0001000, 1'b1});
    tab.push_back('{16'h8888, 4'b1111, 4'b0000, 4'b1111, 2, 7'b0000000, 1'b0});

    // reset values, then async reset mid-scan
    @(negedge clock); @(negedge clock);
    chk("reset seg", bus.seg, 7'b1111111);
    chk("reset digito", bus.digito, 4'hF);
    reset = 1'b0;
    load(16'h8888, 4'hF, 4'h0, 4'hF);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async seg", bus.seg, 7'b1111111);
    chk("async dp", bus.dp, 1'b1);
    chk("async digito", bus.digito, 4'hF);
    chk("async fim", bus.fim_varredura, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clock);
      chk("restart digito", bus.digito, (s < 3) ? 4'b1110 : 4'b1111);
    end

    // scan order, anti-ghost cycle, one fim per scan
    load(16'hA5C3, 4'hF, 4'h0, 4'h0);
    wait_fim();
    check_scan(16'hA5C3, 4'hF, 4'h0, "scan");
    check_scan(16'hA5C3, 4'hF, 4'h0, "scan2");

    // vector table: hex sweep, enable/dp
    foreach (tab[i]) begin
      exp_t e;
      load(tab[i].val, tab[i].hab, tab[i].pis, tab[i].pts);
      e.dig = ~(4'b0001 << tab[i].dig);
      e.seg = tab[i].seg; e.dp = tab[i].dp; e.fim = 1'b0; e.full = 1'b1;
      sb.push_back(e);
      wait_digit(tab[i].dig, ok);
      if (ok) pop_cmp($sformatf("vec%0d", i));
      else void'(sb.pop_front());
    end

    // blink: fase known after reset, two scans visible then two blank
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    load(16'hA5C3, 4'hF, 4'b0001, 4'b0001);
    wait_fim();
    for (int s = 1; s <= 8; s++)
      check_scan(16'hA5C3, {3'b111, ((s / 2) % 2) == 0}, 4'b0001, $sformatf("blink%0d", s));

    // carrega on the tick edge: old digit 0 holds through its tick, new values from digit 1
    load(16'hA5C3, 4'hF, 4'h0, 4'h0);
    wait_fim();
    for (int c = 0; c < 16; c++) begin
      exp_t e;
      logic [15:0] v;
      int s;
      s = c / 4;
      v = (s == 0) ? 16'hA5C3 : 16'h1234;
      e.dig = ((c % 4) == 3) ? 4'hF : ~(4'b0001 << s);
      e.seg = hex_seg[v[4*s +: 4]];
      e.dp = 1'b1; e.fim = (c == 15); e.full = 1'b1;
      sb.push_back(e);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      pop_cmp($sformatf("tickload%0d", c));
      if (c == 2) begin
        bus.carrega = 1'b1; bus.valores = 16'h1234;
      end else if (c == 3) begin
        bus.carrega = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
